// File: rtl/rep_code_tx_if.sv
// Handshake and chip-stream bundle for the repetition-code transmitter.
// master = upstream frame source / chip sink side, slave = rep_code_tx itself.
interface rep_code_tx_if #(
  parameter int DATA_W = 8,
  parameter int REP    = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [REP-1:0]    inj_mask;
  logic              tx_bit;
  logic              tx_valid;
  logic              tx_sof;
  logic              tx_eof;

  modport master (
    output in_valid, in_data, inj_mask,
    input  in_ready, tx_bit, tx_valid, tx_sof, tx_eof
  );

  modport slave (
    input  in_valid, in_data, inj_mask,
    output in_ready, tx_bit, tx_valid, tx_sof, tx_eof
  );
endinterface

// File: rtl/rep_code_tx.sv
// Serializes DATA_W-bit words LSB first, each bit repeated REP chips and XORed with a per-frame mask.
// First chip appears on the accepting edge; in_ready only in IDLE or on the last chip, so frames run back-to-back.
module rep_code_tx #(
  parameter int DATA_W = 8,
  parameter int REP    = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  rep_code_tx_if.slave bus
);
  localparam int CW = (REP > 1) ? $clog2(REP) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CHIP_LAST = CW'(REP - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     chip_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shift_q;
  logic [REP-1:0]    mask_q;
  logic              last_chip;
  logic              accept;

  assign last_chip = (state_q == SEND) && (chip_cnt == CHIP_LAST) && (bit_cnt == BIT_LAST);
  assign accept    = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SEND;
      SEND:    if (last_chip && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The mask rotates once per chip so chip c always sees mask[c]; after REP chips it is back in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chip_cnt <= '0;
      bit_cnt  <= '0;
      shift_q  <= '0;
      mask_q   <= '0;
    end else if (accept) begin
      chip_cnt <= '0;
      bit_cnt  <= '0;
      shift_q  <= bus.in_data;
      mask_q   <= bus.inj_mask;
    end else if (state_q == SEND) begin
      mask_q <= {mask_q[0], mask_q[REP-1:1]};
      if (chip_cnt == CHIP_LAST) begin
        chip_cnt <= '0;
        shift_q  <= shift_q >> 1;
        bit_cnt  <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BW'(1);
      end else begin
        chip_cnt <= chip_cnt + CW'(1);
      end
    end
  end

  // Outputs decode straight from registered state, so an async reset clears them at once.
  always_comb begin
    bus.in_ready = (state_q == IDLE) || last_chip;
    bus.tx_valid = 1'b0;
    bus.tx_bit   = 1'b0;
    bus.tx_sof   = 1'b0;
    bus.tx_eof   = 1'b0;
    if (state_q == SEND) begin
      bus.tx_valid = 1'b1;
      bus.tx_bit   = shift_q[0] ^ mask_q[0];
      bus.tx_sof   = (chip_cnt == '0) && (bit_cnt == '0);
      bus.tx_eof   = last_chip;
    end
  end
endmodule

// File: tb/tb_rep_code_tx.sv
// Scoreboarded bench: accepted frames expand into per-chip expectations; monitors pop and compare each cycle.
module tb_rep_code_tx;
  localparam int DW  = 8;
  localparam int RP  = 5;
  localparam int DW2 = 4;
  localparam int RP2 = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rep_code_tx_if #(.DATA_W(DW),  .REP(RP))  bus ();
  rep_code_tx_if #(.DATA_W(DW2), .REP(RP2)) bus2 ();

  rep_code_tx #(.DATA_W(DW),  .REP(RP))  dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  rep_code_tx #(.DATA_W(DW2), .REP(RP2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  typedef struct packed {
    logic b;
    logic sof;
    logic eof;
    logic grp_end;
    logic dbit;
    logic decodable;
  } exp_t;

  exp_t q[$];
  exp_t q2[$];
  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endfunction

  function automatic void push_frame(input logic [DW-1:0] d, input logic [RP-1:0] m);
    int w;
    exp_t e;
    w = $countones(m);
    for (int b = 0; b < DW; b++)
      for (int c = 0; c < RP; c++) begin
        e.b = d[b] ^ m[c];
        e.sof = (b == 0 && c == 0);
        e.eof = (b == DW-1 && c == RP-1);
        e.grp_end = (c == RP-1);
        e.dbit = d[b];
        e.decodable = (w <= (RP-1)/2);
        q.push_back(e);
      end
  endfunction

  function automatic void push_frame2(input logic [DW2-1:0] d, input logic [RP2-1:0] m);
    int w;
    exp_t e;
    w = $countones(m);
    for (int b = 0; b < DW2; b++)
      for (int c = 0; c < RP2; c++) begin
        e.b = d[b] ^ m[c];
        e.sof = (b == 0 && c == 0);
        e.eof = (b == DW2-1 && c == RP2-1);
        e.grp_end = (c == RP2-1);
        e.dbit = d[b];
        e.decodable = (w <= (RP2-1)/2);
        q2.push_back(e);
      end
  endfunction

  initial begin : mon1
    int ones;
    exp_t e;
    ones = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ones = 0;
      end else if (q.size() == 0) begin
        chk("idle_valid", bus.tx_valid, 0);
        chk("idle_bit", bus.tx_bit, 0);
        chk("idle_sof", bus.tx_sof, 0);
        chk("idle_eof", bus.tx_eof, 0);
        chk("idle_ready", bus.in_ready, 1);
      end else begin
        e = q.pop_front();
        chk("tx_valid", bus.tx_valid, 1);
        chk("tx_bit", bus.tx_bit, e.b);
        chk("tx_sof", bus.tx_sof, e.sof);
        chk("tx_eof", bus.tx_eof, e.eof);
        chk("in_ready", bus.in_ready, e.eof);
        if (bus.tx_bit === 1'b1) ones++;
        if (e.grp_end) begin
          if (e.decodable) chk("vote", ones > RP/2, e.dbit);
          ones = 0;
        end
      end
    end
  end

  initial begin : mon2
    int ones;
    exp_t e;
    ones = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ones = 0;
      end else if (q2.size() == 0) begin
        chk("sweep_idle_valid", bus2.tx_valid, 0);
        chk("sweep_idle_bit", bus2.tx_bit, 0);
        chk("sweep_idle_ready", bus2.in_ready, 1);
      end else begin
        e = q2.pop_front();
        chk("sweep_tx_valid", bus2.tx_valid, 1);
        chk("sweep_tx_bit", bus2.tx_bit, e.b);
        chk("sweep_tx_sof", bus2.tx_sof, e.sof);
        chk("sweep_tx_eof", bus2.tx_eof, e.eof);
        chk("sweep_in_ready", bus2.in_ready, e.eof);
        if (bus2.tx_bit === 1'b1) ones++;
        if (e.grp_end) begin
          if (e.decodable) chk("sweep_vote", ones > RP2/2, e.dbit);
          ones = 0;
        end
      end
    end
  end

  // Offer a frame, wait (bounded) for in_ready, and record it once the accepting edge has passed.
  task automatic send(input logic [DW-1:0] d, input logic [RP-1:0] m, input bit keep_valid);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.inj_mask = m;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus.in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready=%b, expected 1", bus.in_ready);
      bus.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      push_frame(d, m);
      if (!keep_valid) bus.in_valid = 1'b0;
    end
  endtask

  task automatic send2(input logic [DW2-1:0] d, input logic [RP2-1:0] m);
    int n;
    n = 0;
    bus2.in_valid = 1'b1;
    bus2.in_data  = d;
    bus2.inj_mask = m;
    @(negedge clk);
    while (bus2.in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus2.in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL sweep_accept_timeout: in_ready=%b, expected 1", bus2.in_ready);
      bus2.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      push_frame2(d, m);
      bus2.in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q.size() != 0 || q2.size() != 0) && n < 1000) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0 || q2.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d/%0d chips outstanding, expected 0", q.size(), q2.size());
      q.delete();
      q2.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  function automatic logic [RP-1:0] rand_mask();
    logic [RP-1:0] m;
    if ($urandom_range(0, 1) == 0) begin
      m = '0;
      m[$urandom_range(0, RP-1)] = 1'b1;
      m[$urandom_range(0, RP-1)] = 1'b1;
    end else begin
      m = RP'($urandom);
    end
    return m;
  endfunction

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin : stim
    bit keep;
    bus.in_valid = 1'b0;  bus.in_data = '0;  bus.inj_mask = '0;
    bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.inj_mask = '0;
    #1;
    chk("reset_tx_valid", bus.tx_valid, 0);
    chk("reset_tx_bit", bus.tx_bit, 0);
    chk("reset_tx_sof", bus.tx_sof, 0);
    chk("reset_tx_eof", bus.tx_eof, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(8'hA5, 5'b00000, 1'b0);
    wait_drain();

    send(8'hFF, 5'b00000, 1'b1);
    send(8'h00, 5'b00000, 1'b0);
    wait_drain();

    send(8'h00, 5'b00011, 1'b0);
    wait_drain();

    // Stalled upstream with churning inputs must not disturb the frame in flight.
    send(8'h6B, 5'b10000, 1'b1);
    bus.in_data  = DW'($urandom);
    bus.inj_mask = RP'($urandom);
    repeat (15) @(posedge clk);
    #1;
    bus.in_data  = DW'($urandom);
    send(8'hC4, 5'b00000, 1'b0);
    wait_drain();

    send(8'h5A, 5'b00100, 1'b0);
    repeat (16) @(posedge clk);
    #1;
    chk("pre_rst_valid", bus.tx_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_valid", bus.tx_valid, 0);
    chk("rst_async_bit", bus.tx_bit, 0);
    chk("rst_async_sof", bus.tx_sof, 0);
    chk("rst_async_eof", bus.tx_eof, 0);
    chk("rst_async_ready", bus.in_ready, 1);
    q.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", bus.in_ready, 1);
    send(8'h3C, 5'b00000, 1'b0);
    wait_drain();

    send2(4'h9, 3'b000);
    wait_drain();
    send2(4'h6, 3'b010);
    wait_drain();

    for (int i = 0; i < 25; i++) begin
      keep = ($urandom_range(0, 2) == 0);
      send(DW'($urandom), rand_mask(), keep);
      if (!keep) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
      if (i % 5 == 0) send2(DW2'($urandom), RP2'($urandom));
    end
    bus.in_valid = 1'b0;
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rep_code_tx.md
Name: rep_code_tx

Overview:
- Transmitter end of the 5-way majority-vote link: serializes parallel words into a repetition-coded chip stream.
- Each data bit is sent REP consecutive times, so the downstream majority voter recovers it despite up to (REP-1)/2 chip errors.
- A per-frame chip-inversion mask lets benches and BIST deliberately corrupt chips to exercise the voter.

Parameters:
- DATA_W, 8, data bits per frame.
- REP, 5, repetitions per bit; must be odd and >= 3.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream offers in_data/inj_mask.
- in_ready  output  1  block can accept a frame this cycle.
- in_data  input  DATA_W  word to transmit, sent LSB first.
- inj_mask  input  REP  chip inversion mask, applied to every bit group of the frame.
- tx_bit  output  1  current chip.
- tx_valid  output  1  tx_bit carries a frame chip.
- tx_sof  output  1  first chip of frame (bit 0, chip 0).
- tx_eof  output  1  last chip of frame (bit DATA_W-1, chip REP-1).

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - tx_bit=0, tx_valid=0, tx_sof=0, tx_eof=0.
  - State=IDLE, bit_cnt=0, chip_cnt=0, shift and mask registers cleared.
- States: IDLE and SEND.
- in_ready (combinational from state/counters):
  - 1 in IDLE.
  - 1 in SEND only on the last chip (tx_eof=1).
  - 0 otherwise.
- Handshake: a frame is accepted on a rising edge where in_valid && in_ready. in_data and inj_mask are latched on that edge. Inputs are ignored when not accepted.
- Latency: on the edge that accepts a frame, the block registers its first chip. From that edge onward:
  - tx_valid=1, tx_sof=1.
  - tx_bit = in_data[0] ^ inj_mask[0].
- Chip sequence:
  - Chip c (0..REP-1) of bit b (0..DATA_W-1) is data[b] ^ mask[c].
  - chip_cnt advances every cycle. On wrap from REP-1 to 0, bit_cnt increments.
  - A frame is exactly DATA_W*REP consecutive valid cycles with no gaps.
- tx_sof is high only on chip 0 of bit 0. tx_eof is high only on chip REP-1 of bit DATA_W-1.
- End of frame, new frame accepted on the last chip: back-to-back, no idle cycle. The next edge loads chip 0 of the new frame, tx_sof=1.
- End of frame, no new frame: go to IDLE. tx_valid=0 and tx_bit=0 (forced low in IDLE).
- Upstream stalls: in_valid held high mid-frame is not consumed. in_data changing mid-frame has no effect on the current frame.
- Counter widths: clog2(REP) and clog2(DATA_W), minimum 1 bit each. Counters never exceed REP-1 / DATA_W-1.
- Reset mid-frame: the frame is aborted immediately (asynchronously) and all outputs go to their reset values. After release, in_ready=1 and the next accepted frame starts at bit 0, chip 0.
- inj_mask=0: the stream is a pure repetition code.
- Mask popcount <= (REP-1)/2: the stream remains majority-decodable. This block does not check mask weight.

Test Plan:
- Basic frame: DATA_W=8, REP=5, in_data=0xA5, inj_mask=0, single handshake.
  -> 40 valid cycles, tx_bit = 11111 00000 11111 00000 00000 11111 00000 11111.
  -> tx_sof on cycle 1 only, tx_eof on cycle 40 only, tx_valid=0 from cycle 41.
- Back-to-back: 0xFF then 0x00, in_valid held high.
  -> in_ready=1 only on cycle 40; 80 contiguous valid cycles (40 ones, then 40 zeros).
  -> tx_sof on cycles 1 and 41.
- Error injection: in_data=0x00, inj_mask=5'b00011.
  -> every 5-chip group is 1,1,0,0,0; a majority of each group decodes to 0x00.
- Stall/hold: in_valid=1 with a new in_data change mid-frame.
  -> in_ready=0 on cycles 1-39; the transmitted stream is unchanged; the new word is accepted on cycle 40.
- Reset mid-frame: assert rst_n=0 at chip 17.
  -> all outputs 0 without waiting for a clock edge.
  -> after release, in_ready=1; 0x3C then produces a fresh 40-cycle frame starting at bit 0.
- Parameter sweep: REP=3, DATA_W=4, in_data=0x9.
  -> 12 cycles: 111 000 000 111; tx_eof on cycle 12.
